// File: rtl/fm_pkg.sv
// rtl/fm_pkg.sv - shared widths, limits and FSM encoding for the FM audio path
// Purpose: common definitions used by the audio preconditioner, the modulator
//          and the demodulator so sample formats and clamp limits agree.
// Contents: sample/difference/emphasis widths, Q1.15 shift, 16-bit clamp
//           limits, preconditioner FSM state type.
package fm_pkg;

  localparam int SAMPLE_W  = 16;      // modulator sample width
  localparam int DIFF_W    = 17;      // DC-removed sample width
  localparam int EMPH_W    = 19;      // pre-emphasised sample width
  localparam int Q15_SHIFT = 15;      // Q1.15 scaling
  localparam int SAT_MAX   = 32767;
  localparam int SAT_MIN   = -32768;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_DCB,
    ST_PRE,
    ST_SAT
  } fm_state_t;

endpackage

// File: rtl/sat_s16.sv
// rtl/sat_s16.sv - combinational 19-bit to 16-bit signed clamp
// Purpose: clamps a pre-emphasised sample into the 16-bit signed range.
// Ports:
//   din   in   EMPH_W    signed value to clamp
//   dout  out  SAMPLE_W  clamped signed value
module sat_s16
  import fm_pkg::*;
(
  input  logic signed [EMPH_W-1:0]   din,
  output logic signed [SAMPLE_W-1:0] dout
);

  localparam logic signed [EMPH_W-1:0] HI = EMPH_W'(SAT_MAX);
  localparam logic signed [EMPH_W-1:0] LO = EMPH_W'(SAT_MIN);

  always_comb begin
    if (din > HI) begin
      dout = SAMPLE_W'(SAT_MAX);
    end else if (din < LO) begin
      dout = SAMPLE_W'(SAT_MIN);
    end else begin
      dout = din[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/fm_audio_precond.sv
// rtl/fm_audio_precond.sv - ADC sample conditioning ahead of the FM modulator
// Purpose: offset-binary to two's complement, DC removal, pre-emphasis and
//          16-bit saturation; output held steady between samples.
// Ports:
//   clk           in   1        system clock
//   rst_n         in   1        asynchronous active-low reset
//   enable        in   1        0 idles the pipeline and forces sample_out to 0
//   adc_valid     in   1        one-cycle strobe qualifying adc_raw
//   adc_raw       in   ADC_W    raw offset-binary ADC code
//   sample_out    out  16       signed conditioned sample
//   sample_valid  out  1        one-cycle pulse when sample_out updates
//   busy          out  1        FSM outside IDLE
//   drop_cnt      out  16       saturating count of strobes dropped while busy
module fm_audio_precond
  import fm_pkg::*;
#(
  parameter int ADC_W        = 12,
  parameter int DC_SHIFT     = 10,
  parameter int PRE_A        = 19661,
  parameter int MUTE_SAMPLES = 2048
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       adc_valid,
  input  logic [ADC_W-1:0]           adc_raw,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       busy,
  output logic [15:0]                drop_cnt
);

  localparam int          ACC_W     = SAMPLE_W + DC_SHIFT + 1;
  localparam int          PROD_W    = 2 * DIFF_W;
  localparam logic [15:0] PRE_A_U   = 16'(PRE_A);
  localparam logic [15:0] MUTE_INIT = 16'(MUTE_SAMPLES);

  fm_state_t                 state, next_state;
  logic [ADC_W-1:0]          raw_q;
  logic signed [SAMPLE_W-1:0] x_q;
  logic signed [DIFF_W-1:0]  y_q, y_prev;
  logic signed [EMPH_W-1:0]  e_q;
  logic signed [ACC_W-1:0]   dc_acc;
  logic [15:0]               mute_cnt;
  logic                      en_q;

  logic signed [ADC_W-1:0]    raw_tc;
  logic signed [DIFF_W-1:0]   dc, y_next;
  logic signed [PROD_W-1:0]   prod;
  logic signed [EMPH_W-1:0]   e_next;
  logic signed [SAMPLE_W-1:0] e_sat;
  logic                       prod_unused;

  // Flipping the MSB turns offset-binary into two's complement.
  assign raw_tc = {~raw_q[ADC_W-1], raw_q[ADC_W-2:0]};

  // Arithmetic shift of the pre-update accumulator is just its top bits.
  assign dc     = dc_acc[ACC_W-1:DC_SHIFT];
  assign y_next = DIFF_W'(x_q) - dc;

  // The only multiplier: unsigned Q1.15 coefficient times previous y.
  assign prod        = PROD_W'($signed({1'b0, PRE_A_U})) * PROD_W'(y_prev);
  assign e_next      = EMPH_W'(y_q) - $signed(prod[Q15_SHIFT +: EMPH_W]);
  assign prod_unused = ^prod[Q15_SHIFT-1:0];

  assign busy = (state != ST_IDLE);

  sat_s16 u_sat (
    .din  (e_q),
    .dout (e_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (adc_valid) next_state = ST_CONV;
        ST_CONV: next_state = ST_DCB;
        ST_DCB:  next_state = ST_PRE;
        ST_PRE:  next_state = ST_SAT;
        ST_SAT:  next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      y_prev       <= '0;
      e_q          <= '0;
      dc_acc       <= '0;
      mute_cnt     <= MUTE_INIT;
      en_q         <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      en_q         <= enable;
      sample_valid <= 1'b0;

      if (enable && adc_valid && busy && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end

      if (!enable) begin
        // Aborts any in-flight sample; filter history is left intact.
        sample_out <= '0;
      end else begin
        if (!en_q) begin
          mute_cnt <= MUTE_INIT;
        end
        case (state)
          ST_IDLE: if (adc_valid) raw_q <= adc_raw;
          ST_CONV: x_q <= SAMPLE_W'(raw_tc) <<< (SAMPLE_W - ADC_W);
          ST_DCB: begin
            y_q    <= y_next;
            dc_acc <= dc_acc + ACC_W'(y_next);
          end
          ST_PRE: begin
            e_q    <= e_next;
            y_prev <= y_q;
          end
          ST_SAT: begin
            sample_valid <= 1'b1;
            if (mute_cnt != 16'd0) begin
              sample_out <= '0;
              mute_cnt   <= mute_cnt - 16'd1;
            end else begin
              sample_out <= e_sat;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fm_audio_precond.sv
// tb/tb_fm_audio_precond.sv - scoreboard bench for fm_audio_precond
module tb_fm_audio_precond;

  logic              clk = 1'b0;
  logic              rst_n, enable, adc_valid;
  logic [11:0]       adc_raw;
  logic signed [15:0] out0, out4;
  logic              v0, v4, b0, b4;
  logic [15:0]       drop0, drop4;

  always #5 clk = ~clk;

  fm_audio_precond #(.ADC_W(12), .DC_SHIFT(10), .PRE_A(19661), .MUTE_SAMPLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_valid(adc_valid), .adc_raw(adc_raw),
    .sample_out(out0), .sample_valid(v0), .busy(b0), .drop_cnt(drop0));

  fm_audio_precond #(.ADC_W(12), .DC_SHIFT(10), .PRE_A(19661), .MUTE_SAMPLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_valid(adc_valid), .adc_raw(adc_raw),
    .sample_out(out4), .sample_valid(v4), .busy(b4), .drop_cnt(drop4));

  int     checks = 0;
  int     errors = 0;
  int     q0[$];
  int     q4[$];
  longint m_acc;
  int     m_yprev;
  int     m_mute4;
  int     prev;
  bit     sb_ignore = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc   = 0;
    m_yprev = 0;
    m_mute4 = 4;
  endtask

  // Reference: plain integer arithmetic on the filter equations.
  function automatic void model(input logic [11:0] raw);
    int x, dc, y, t, e;
    x       = (int'(raw) - 2048) * 16;
    dc      = int'(m_acc >>> 10);
    y       = x - dc;
    m_acc   = m_acc + y;
    t       = int'((longint'(19661) * m_yprev) >>> 15);
    e       = y - t;
    m_yprev = y;
    if (e > 32767) e = 32767;
    if (e < -32768) e = -32768;
    q0.push_back(e);
    if (m_mute4 > 0) begin
      q4.push_back(0);
      m_mute4--;
    end else begin
      q4.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && !sb_ignore) begin
      if (v0) begin
        if (q0.size() == 0) check("u0 unexpected pulse", v0, 0);
        else check("u0 sample", out0, q0.pop_front());
      end
      if (v4) begin
        if (q4.size() == 0) check("u4 unexpected pulse", v4, 0);
        else check("u4 sample", out4, q4.pop_front());
      end
    end
  end

  task automatic strobe(input logic [11:0] raw, input int extra);
    @(negedge clk);
    adc_valid = 1'b1;
    adc_raw   = raw;
    model(raw);
    @(negedge clk);
    adc_valid = 1'b0;
    repeat (4 + extra) @(negedge clk);
  endtask

  task automatic strobe_lat(input logic [11:0] raw);
    int lat = -1;
    @(negedge clk);
    adc_valid = 1'b1;
    adc_raw   = raw;
    model(raw);
    @(posedge clk);
    #1 adc_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (v0) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, 4);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; adc_valid = 1'b0; adc_raw = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst out0", out0, 0);   check("rst valid0", v0, 0);
    check("rst busy0", b0, 0);    check("rst drop0", drop0, 0);
    check("rst out4", out4, 0);   check("rst valid4", v4, 0);
    check("rst busy4", b4, 0);    check("rst drop4", drop4, 0);
    rst_n = 1'b1;

    strobe_lat(12'h800);
    check("fmt 0x800", out0, 0);

    strobe(12'hC00, 0);
    check("dc first", out0, 16384);
    prev = out0;
    for (int i = 0; i < 799; i++) begin
      strobe(12'hC00, 0);
      check("dc decay", (out0 <= prev) && (out0 >= 0), 1);
      prev = out0;
    end

    for (int i = 0; i < 64; i++) strobe((i % 2) ? 12'hFFF : 12'h000, 0);
    check("sat hi", out0, 32767);

    repeat (200) strobe(12'($urandom_range(0, 4095)), $urandom_range(0, 3));

    @(negedge clk); adc_valid = 1'b1; adc_raw = 12'h9A5; model(12'h9A5);
    @(negedge clk); adc_valid = 1'b0;
    @(negedge clk); adc_valid = 1'b1; adc_raw = 12'h123;
    @(negedge clk); adc_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("overrun drop0", drop0, 1);
    check("overrun drop4", drop4, 1);

    @(negedge clk); enable = 1'b0;
    repeat (2) @(negedge clk); adc_valid = 1'b1; adc_raw = 12'hFFF;
    @(negedge clk); adc_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("disabled no drop", drop0, 1);
    check("disabled out0", out0, 0);
    enable = 1'b1; m_mute4 = 4;
    repeat (4) strobe(12'hFFF, 0);
    check("mute hold", out4, 0);
    strobe(12'hFFF, 0);

    @(negedge clk); adc_valid = 1'b1; adc_raw = 12'hFFF;
    @(negedge clk); adc_valid = 1'b0;
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    check("abort out0", out0, 0);
    check("abort out4", out4, 0);
    check("abort busy", b0, 0);
    repeat (8) @(negedge clk);
    enable = 1'b1; m_mute4 = 4;
    repeat (6) strobe(12'hFFF, 0);

    sb_ignore = 1'b1;
    @(negedge clk); adc_valid = 1'b1;
    for (int i = 0; i < 82000; i++) begin
      adc_raw = 12'($urandom);
      @(negedge clk);
    end
    adc_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("drop sat0", drop0, 65535);
    check("drop sat4", drop4, 65535);

    @(negedge clk); adc_valid = 1'b1; adc_raw = 12'h3C7;
    @(negedge clk); adc_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("busy in PRE", b0, 1);
    rst_n = 1'b0;
    #1;
    check("arst out0", out0, 0);  check("arst valid0", v0, 0);
    check("arst busy0", b0, 0);   check("arst drop0", drop0, 0);
    check("arst out4", out4, 0);  check("arst drop4", drop4, 0);
    q0.delete(); q4.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_ignore = 1'b0;
    strobe_lat(12'h800);
    check("post-reset 0x800", out0, 0);

    repeat (10) @(negedge clk);
    check("u0 missing pulses", q0.size(), 0);
    check("u4 missing pulses", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
